booth_mult_pipe: RTL and testbench

//  Parametrised, pipelined radix-4 Booth multiplier with valid/ready flow control and per-operation

---
 rtl/booth_mult_pipe_if.sv | 17 +
 rtl/booth_mult_pipe.sv | 112 +++++++++++
 tb/tb_booth_mult_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/booth_mult_pipe_if.sv
// booth_mult_pipe_if: operand/result handshake bundle for the Booth multiplier pipeline
interface booth_mult_pipe_if #(parameter int DWIDTH = 16);
   logic                  in_vld;
   logic                  in_rdy;
   logic                  in_signed;
   logic [DWIDTH-1:0]     in_a;
   logic [DWIDTH-1:0]     in_b;
   logic                  out_vld;
   logic                  out_rdy;
   logic [2*DWIDTH-1:0]   out_sum;
   logic [2*DWIDTH-1:0]   out_carry;
   logic [2*DWIDTH-1:0]   out_prod;
   modport master (output in_vld, in_signed, in_a, in_b, out_rdy,
                   input  in_rdy, out_vld, out_sum, out_carry, out_prod);
   modport slave  (input  in_vld, in_signed, in_a, in_b, out_rdy,
                   output in_rdy, out_vld, out_sum, out_carry, out_prod);
endinterface

// File: rtl/booth_mult_pipe.sv
// booth_mult_pipe: pipelined radix-4 Booth multiplier, signed/unsigned, carry-save plus resolved product
module booth_mult_pipe #(
   parameter int DWIDTH   = 16,
   parameter int PIPE_CSA = 1
) (
   input  logic                clk,
   input  logic                rst,
   booth_mult_pipe_if.slave    bus,
   output logic [31:0]         op_cnt
);
   localparam int W = 2 * DWIDTH;
   localparam int N = DWIDTH / 2 + 1;
   localparam int R = N + 1;

   logic              v1, ld1, ld3, nxt1, vm;
   logic [DWIDTH+2:0] ax;
   logic [DWIDTH:0]   be;
   logic [W-1:0]      pp [R];
   logic [W-1:0]      pp_q [R];
   logic [W-1:0]      cs, cc, t, ms, mc;

   // One Booth row: one's-complemented for negative digits, sign-extended to full width
   function automatic logic [W-1:0] row(input logic [2:0] d, input logic [DWIDTH:0] b);
      logic [DWIDTH+1:0] m;
      m = (d[1] ^ d[0]) ? {b[DWIDTH], b} : (d[2] != d[1] && d[1] == d[0]) ? {b, 1'b0} : '0;
      if (d[2]) m = ~m;
      return {{(W-DWIDTH-2){m[DWIDTH+1]}}, m};
   endfunction

   // Last row collects the +1 completion bits of every negative digit
   always_comb begin
      ax = {{2{bus.in_signed & bus.in_a[DWIDTH-1]}}, bus.in_a, 1'b0};
      be = {bus.in_signed & bus.in_b[DWIDTH-1], bus.in_b};
      pp[N] = '0;
      for (int i = 0; i < N; i++) begin
         pp[i] = row(ax[2*i +: 3], be) << (2*i);
         pp[N][2*i] = ax[2*i+2];
      end
   end

   always_comb begin
      cs = '0;
      cc = '0;
      t  = '0;
      for (int r = 0; r < R; r++) begin
         t  = cs ^ cc ^ pp_q[r];
         cc = ((cs & cc) | (cs & pp_q[r]) | (cc & pp_q[r])) << 1;
         cs = t;
      end
   end

   assign ld3        = ~bus.out_vld | bus.out_rdy;
   assign ld1        = ~v1 | nxt1;
   assign bus.in_rdy = ld1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         pp_q <= '{default: '0};
      end else if (ld1) begin
         v1 <= bus.in_vld;
         if (bus.in_vld) pp_q <= pp;
      end
   end

   if (PIPE_CSA != 0) begin : g_csa
      logic         v2;
      logic [W-1:0] s2, c2;
      assign nxt1 = ~v2 | ld3;
      assign vm   = v2;
      assign ms   = s2;
      assign mc   = c2;
      always_ff @(posedge clk) begin
         if (rst) begin
            v2 <= 1'b0;
            s2 <= '0;
            c2 <= '0;
         end else if (nxt1) begin
            v2 <= v1;
            if (v1) begin
               s2 <= cs;
               c2 <= cc;
            end
         end
      end
   end else begin : g_nocsa
      assign nxt1 = ld3;
      assign vm   = v1;
      assign ms   = cs;
      assign mc   = cc;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_vld   <= 1'b0;
         bus.out_sum   <= '0;
         bus.out_carry <= '0;
         bus.out_prod  <= '0;
         op_cnt        <= '0;
      end else begin
         if (bus.out_vld && bus.out_rdy) op_cnt <= op_cnt + 32'd1;
         if (ld3) begin
            bus.out_vld <= vm;
            if (vm) begin
               bus.out_sum   <= ms;
               bus.out_carry <= mc;
               bus.out_prod  <= ms + mc;
            end
         end
      end
   end
endmodule

// File: tb/tb_booth_mult_pipe.sv
// tb_booth_mult_pipe: directed and random checks of the Booth pipeline against an arithmetic product model
module tb_booth_mult_pipe;
   localparam int DW = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] op_cnt, op_cnt0;
   booth_mult_pipe_if #(.DWIDTH(DW)) bus ();
   booth_mult_pipe_if #(.DWIDTH(DW)) bus0 ();
   booth_mult_pipe #(.DWIDTH(DW), .PIPE_CSA(1)) dut  (.clk(clk), .rst(rst), .bus(bus),  .op_cnt(op_cnt));
   booth_mult_pipe #(.DWIDTH(DW), .PIPE_CSA(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .op_cnt(op_cnt0));
   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;
   int n_acc = 0;
   int n_spur = 0;
   logic acc;
   logic [31:0] exp_q [$];

   function automatic logic [31:0] ref_prod(input logic s, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] xa, xb;
      xa = s ? {{16{a[15]}}, a} : {16'b0, a};
      xb = s ? {{16{b[15]}}, b} : {16'b0, b};
      return xa * xb;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
   endtask

   task automatic drive(input logic s, input logic [15:0] a, input logic [15:0] b);
      bus.in_vld    = 1'b1;
      bus.in_signed = s;
      bus.in_a      = a;
      bus.in_b      = b;
   endtask

   task automatic drive_rand();
      drive(1'($urandom), 16'($urandom), 16'($urandom));
   endtask

   // Settle, score this cycle's retire/accept, then advance to the next negedge
   task automatic cyc();
      logic [31:0] e;
      #1;
      acc = bus.in_vld && bus.in_rdy;
      if (bus.out_vld && bus.out_rdy) begin
         if (exp_q.size() == 0) n_spur++;
         else begin
            e = exp_q.pop_front();
            chk("prod", bus.out_prod, e);
            chk("sum_carry", bus.out_sum + bus.out_carry, e);
         end
      end
      if (acc) begin
         exp_q.push_back(ref_prod(bus.in_signed, bus.in_a, bus.in_b));
         n_acc++;
      end
      @(negedge clk);
   endtask

   task automatic op1(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] want);
      int lat;
      drive(s, a, b);
      cyc();
      chk({tag, "_acc"}, acc, 1);
      bus.in_vld = 1'b0;
      lat = 1;
      while (!bus.out_vld && lat < 10) begin
         cyc();
         lat++;
      end
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_prod"}, bus.out_prod, want);
      cyc();
   endtask

   task automatic op0(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] want);
      int lat;
      bus0.in_vld    = 1'b1;
      bus0.in_signed = s;
      bus0.in_a      = a;
      bus0.in_b      = b;
      #1;
      chk({tag, "_rdy"}, bus0.in_rdy, 1);
      @(negedge clk);
      bus0.in_vld = 1'b0;
      lat = 1;
      while (!bus0.out_vld && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_prod"}, bus0.out_prod, want);
      chk({tag, "_sc"}, bus0.out_sum + bus0.out_carry, want);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] sp, ss, sc;
      int n0;
      bus.in_vld = 1'b0;  bus.in_signed = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.out_rdy = 1'b1;
      bus0.in_vld = 1'b0; bus0.in_signed = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.out_rdy = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rdy", bus.in_rdy, 1);
      chk("rst_vld", bus.out_vld, 0);
      chk("rst_prod", bus.out_prod, 0);
      chk("rst_sum", bus.out_sum, 0);
      chk("rst_carry", bus.out_carry, 0);
      chk("rst_cnt", op_cnt, 0);

      op1("u_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
      op1("s_ffff", 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001);
      op1("s_8000_7fff", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
      op1("s_8000_8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000);

      for (int i = 0; i < 64; i++) begin
         drive_rand();
         chk("b2b_rdy", bus.in_rdy, 1);
         cyc();
      end
      bus.in_vld = 1'b0;
      for (int g = 0; g < 10 && exp_q.size() > 0; g++) cyc();
      chk("b2b_drain", exp_q.size(), 0);
      chk("b2b_cnt", op_cnt, 68);

      bus.out_rdy = 1'b0;
      drive_rand();
      n0 = n_acc;
      sp = '0; ss = '0; sc = '0;
      for (int i = 0; i < 10; i++) begin
         if (i == 4) begin
            sp = bus.out_prod;
            ss = bus.out_sum;
            sc = bus.out_carry;
         end
         cyc();
         if (acc) drive_rand();
      end
      chk("stall_accepts", n_acc - n0, 3);
      chk("stall_rdy", bus.in_rdy, 0);
      chk("stall_vld", bus.out_vld, 1);
      chk("stall_prod", bus.out_prod, sp);
      chk("stall_sum", bus.out_sum, ss);
      chk("stall_carry", bus.out_carry, sc);
      bus.out_rdy = 1'b1;
      for (int g = 0; g < 10; g++) begin
         cyc();
         if (acc) break;
      end
      chk("pend_acc", acc, 1);
      bus.in_vld = 1'b0;
      for (int g = 0; g < 10 && exp_q.size() > 0; g++) cyc();
      chk("stall_drain", exp_q.size(), 0);
      chk("stall_cnt", op_cnt, 72);

      for (int i = 0; i < 3; i++) begin
         drive_rand();
         cyc();
      end
      bus.in_vld = 1'b0;
      bus.out_rdy = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("mid_rst_vld", bus.out_vld, 0);
      chk("mid_rst_prod", bus.out_prod, 0);
      chk("mid_rst_sum", bus.out_sum, 0);
      chk("mid_rst_carry", bus.out_carry, 0);
      chk("mid_rst_cnt", op_cnt, 0);
      bus.out_rdy = 1'b1;
      n_spur = 0;
      repeat (8) cyc();
      chk("mid_rst_ghost", n_spur, 0);
      chk("mid_rst_cnt2", op_cnt, 0);

      op0("p0_1234", 1'b0, 16'h1234, 16'h5678, 32'h06260060);
      for (int i = 0; i < 6; i++) begin
         logic s;
         logic [15:0] a, b;
         s = 1'($urandom);
         a = 16'($urandom);
         b = 16'($urandom);
         op0("p0_rand", s, a, b, ref_prod(s, a, b));
      end
      chk("p0_cnt", op_cnt0, 7);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
